// File: rtl/quartz_spi_host.sv
// quartz_spi_host: SPI mode-0 host that reads one length-prefixed,
// XOR-checksummed frame. Option macro: QUARTZ_SPI_HOST_IRQ_EN.
module quartz_spi_host #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 31
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       start,
  input  logic       irq_n,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] len,
  output logic       csum_err,
  output logic       len_err
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, TAIL, GAP
  } state_t;

  typedef enum logic [1:0] {
    PH_LEN, PH_DATA, PH_CSUM
  } phase_t;

  localparam logic [8:0] DIV_M1  = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_M1  = 9'(2 * CLK_DIV - 1);
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

  state_t     state;
  phase_t     phase;
  logic [8:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] run_x;
  logic [7:0] remain;
  logic       armed;
  logic       go;

`ifdef QUARTZ_SPI_HOST_IRQ_EN
  logic irq_s1;
  logic irq_s2;

  // two-flop synchronizer for the asynchronous irq_n line
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1 <= 1'b1;
      irq_s2 <= 1'b1;
    end else begin
      irq_s1 <= irq_n;
      irq_s2 <= irq_s1;
    end
  end

  assign go = armed & (start | ~irq_s2);
`else
  logic unused_irq;
  assign unused_irq = irq_n;
  assign go = armed & start;
`endif

  assign spi_mosi = 1'b0;

  // frame sequencer: chip select, spi clock, byte evaluation
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= PH_LEN;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      run_x    <= '0;
      remain   <= '0;
      armed    <= 1'b0;
      spi_clk  <= 1'b0;
      spi_cs_n <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      len      <= '0;
      csum_err <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      done  <= 1'b0;
      armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (go) begin
            state    <= SETUP;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            bit_cnt  <= '0;
            phase    <= PH_LEN;
            len      <= '0;
            csum_err <= 1'b0;
            len_err  <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt == DIV_M1) begin
            cnt     <= '0;
            spi_clk <= 1'b1;
            shreg   <= {shreg[6:0], spi_miso};
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        SHIFT: begin
          if (cnt != DIV_M1) begin
            cnt <= cnt + 9'd1;
          end else if (!spi_clk) begin
            cnt     <= '0;
            spi_clk <= 1'b1;
            shreg   <= {shreg[6:0], spi_miso};
          end else begin
            cnt     <= '0;
            spi_clk <= 1'b0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              unique case (phase)
                PH_LEN: begin
                  len    <= shreg;
                  run_x  <= 8'hCC ^ shreg;
                  remain <= shreg;
                  if (shreg > LEN_MAX) begin
                    len_err <= 1'b1;
                    state   <= TAIL;
                  end else if (shreg == 8'd0) begin
                    phase <= PH_CSUM;
                  end else begin
                    phase <= PH_DATA;
                  end
                end
                PH_DATA: begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                  run_x    <= run_x ^ shreg;
                  remain   <= remain - 8'd1;
                  state    <= HOLD;
                  if (remain == 8'd1) begin
                    phase <= PH_CSUM;
                  end
                end
                PH_CSUM: begin
                  csum_err <= (shreg != run_x);
                  state    <= TAIL;
                end
                default: begin
                  state <= TAIL;
                end
              endcase
            end
          end
        end
        HOLD: begin
          if (rx_ready) begin
            rx_valid <= 1'b0;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        TAIL: begin
          if (cnt == DIV_M1) begin
            cnt      <= '0;
            spi_cs_n <= 1'b1;
            done     <= 1'b1;
            state    <= GAP;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_M1) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quartz_spi_host.sv
// tb_quartz_spi_host: responder model plus payload scoreboard
// for quartz_spi_host frames, stalls, length limits and reset.
module tb_quartz_spi_host;

  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 31;
  localparam int BUDGET  = 4000;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       irq_n = 1'b1;
  logic       spi_miso = 1'b0;
  logic       rx_ready = 1'b1;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic [7:0] len;
  logic       csum_err;
  logic       len_err;

  quartz_spi_host #(
    .CLK_DIV(CLK_DIV),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .start   (start),
    .irq_n   (irq_n),
    .spi_clk (spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .busy    (busy),
    .done    (done),
    .len     (len),
    .csum_err(csum_err),
    .len_err (len_err)
  );

  always #5 clk_in = ~clk_in;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] resp [0:257];
  logic [7:0] pay  [0:255];
  int         resp_len = 0;
  logic [7:0] exp_q [$];
  int         rises = 0;
  int         falls = 0;
  int         dones = 0;
  int         hs = 0;
  logic       prev_sclk = 1'b0;
  logic       prev_cs = 1'b1;
  bit         stall_ok = 1'b1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // responder: bit index is the number of spi_clk falls seen
  task automatic set_miso();
    int idx;
    int b;
    idx = falls / 8;
    b = 7 - (falls % 8);
    if (idx < resp_len) spi_miso = resp[idx][b];
    else spi_miso = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk_in);
    if (prev_cs && !spi_cs_n) begin
      rises = 0;
      falls = 0;
    end else begin
      if (!prev_sclk && spi_clk) rises++;
      if (prev_sclk && !spi_clk) falls++;
    end
    prev_sclk = spi_clk;
    prev_cs = spi_cs_n;
    if (done) dones++;
    set_miso();
  endtask

  // csum < 0 means use the correct checksum
  task automatic make_frame(input int n, input int csum);
    logic [7:0] x;
    resp[0] = 8'(n);
    x = 8'hCC ^ 8'(n);
    if (n > MAX_LEN) begin
      resp_len = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        resp[i+1] = pay[i];
        x = x ^ pay[i];
        exp_q.push_back(pay[i]);
      end
      resp[n+1] = (csum < 0) ? x : 8'(csum);
      resp_len = n + 2;
    end
  endtask

  task automatic run_frame(input int stall_idx,
                           input int stall_cyc,
                           input bit extra_start,
                           input int abort_rise);
    int pidx;
    int stall_left;
    int cyc;
    bit stalled;
    bit aborted;
    logic [7:0] held;
    pidx = 0;
    stall_left = 0;
    cyc = 0;
    stalled = 1'b0;
    aborted = 1'b0;
    held = '0;
    dones = 0;
    hs = 0;
    rx_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_cs", spi_cs_n, 0);
    check("clear_len", len, 0);
    check("clear_errs", {csum_err, len_err}, 0);
    while (!(dones > 0 && !busy) && cyc < BUDGET
           && !aborted) begin
      tick();
      cyc++;
      start = extra_start && (cyc == 40);
      if (done) check("done_cs", spi_cs_n, 1);
      if (abort_rise > 0 && rises == abort_rise) begin
        rst_n = 1'b0;
        #1;
        check("rst_cs", spi_cs_n, 1);
        check("rst_sclk", spi_clk, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", rx_valid, 0);
        aborted = 1'b1;
      end else if (rx_valid) begin
        if (pidx == stall_idx && !stalled) begin
          stalled = 1'b1;
          stall_left = stall_cyc;
          held = rx_data;
        end
        if (stall_left > 0) begin
          rx_ready = 1'b0;
          stall_left--;
          if (spi_clk !== 1'b0 || rx_data !== held)
            stall_ok = 1'b0;
        end else begin
          rx_ready = 1'b1;
          hs++;
          pidx++;
          if (exp_q.size() == 0)
            check("rx_unexpected", 1, 0);
          else
            check("rx_data", rx_data, exp_q.pop_front());
        end
      end else begin
        rx_ready = 1'b1;
      end
    end
    start = 1'b0;
    rx_ready = 1'b1;
    if (!aborted) check("frame_end", cyc < BUDGET, 1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_state",
          {spi_clk, spi_mosi, busy, done, rx_valid}, 0);
    check("rst_regs", {len, rx_data, csum_err, len_err}, 0);

    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_first_cycle", busy, 0);
    repeat (2) tick();

    pay[0] = 8'h00; pay[1] = 8'h01; pay[2] = 8'h01;
    pay[3] = 8'h00; pay[4] = 8'h00; pay[5] = 8'h08;
    make_frame(6, -1);
    run_frame(-1, 0, 1'b1, 0);
    check("s1_rises", rises, 64);
    check("s1_dones", dones, 1);
    check("s1_hs", hs, 6);
    check("s1_len", len, 6);
    check("s1_errs", {csum_err, len_err}, 0);
    check("s1_idle", {busy, spi_cs_n}, 2'b01);

    make_frame(0, -1);
    run_frame(-1, 0, 1'b0, 0);
    check("s2_rises", rises, 16);
    check("s2_hs", hs, 0);
    check("s2_len", len, 0);
    check("s2_csum", csum_err, 0);

    pay[0] = 8'hAA; pay[1] = 8'h55;
    make_frame(2, 8'h00);
    run_frame(-1, 0, 1'b0, 0);
    check("s3_rises", rises, 32);
    check("s3_hs", hs, 2);
    check("s3_csum", csum_err, 1);
    repeat (5) tick();
    check("s3_hold", {csum_err, len}, {1'b1, 8'd2});

    make_frame(8'h40, -1);
    run_frame(-1, 0, 1'b0, 0);
    check("s4_rises", rises, 8);
    check("s4_dones", dones, 1);
    check("s4_len_err", len_err, 1);
    check("s4_len", len, 8'h40);

    for (int i = 0; i < MAX_LEN; i++)
      pay[i] = 8'($urandom_range(0, 255));
    make_frame(MAX_LEN, -1);
    run_frame(-1, 0, 1'b0, 0);
    check("max_rises", rises, 8 * (MAX_LEN + 2));
    check("max_hs", hs, MAX_LEN);
    check("max_errs", {csum_err, len_err}, 0);

    make_frame(MAX_LEN + 1, -1);
    run_frame(-1, 0, 1'b0, 0);
    check("over_rises", rises, 8);
    check("over_len_err", len_err, 1);

    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    make_frame(3, -1);
    stall_ok = 1'b1;
    run_frame(1, 20, 1'b0, 0);
    check("s5_stall_flat", stall_ok, 1);
    check("s5_rises", rises, 40);
    check("s5_hs", hs, 3);
    check("s5_csum", csum_err, 0);

    pay[0] = 8'h00; pay[1] = 8'h01; pay[2] = 8'h01;
    pay[3] = 8'h00; pay[4] = 8'h00; pay[5] = 8'h08;
    make_frame(6, -1);
    run_frame(-1, 0, 1'b0, 26);
    repeat (4) tick();
    check("s6_no_done", dones, 0);
    check("s6_held", {busy, spi_cs_n, len}, {2'b01, 8'd0});
    exp_q.delete();
    rst_n = 1'b1;
    tick();

`ifdef QUARTZ_SPI_HOST_IRQ_EN
    begin
      int w;
      make_frame(0, -1);
      dones = 0;
      irq_n = 1'b0;
      w = 0;
      while (!busy && w < 4) begin
        tick();
        w++;
      end
      check("s6_irq_start", busy, 1);
      irq_n = 1'b1;
      w = 0;
      while (!(dones > 0 && !busy) && w < BUDGET) begin
        tick();
        w++;
      end
      check("s6_irq_frame", {dones, rises}, {32'd1, 32'd16});
    end
`else
    make_frame(0, -1);
    run_frame(-1, 0, 1'b0, 0);
    check("s6_recover", rises, 16);
    check("s6_recover_done", dones, 1);
`endif
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
